// File: rtl/board_if.sv
// board_if: move requests, screen enables and board/result outputs of board_ctl.
interface board_if;
   logic       start_en;
   logic       choice_en;
   logic       first_player;
   logic       move_valid;
   logic [3:0] move_square;
   logic       new_game;
   logic [8:0] square_occ;
   logic [8:0] square_color;
   logic       turn;
   logic       move_ack;
   logic       move_err;
   logic       game_over;
   logic       winner_valid;
   logic       winner;
   logic [7:0] win_line;

   modport master (
      output start_en, choice_en, first_player, move_valid, move_square, new_game,
      input  square_occ, square_color, turn, move_ack, move_err, game_over,
             winner_valid, winner, win_line
   );

   modport slave (
      input  start_en, choice_en, first_player, move_valid, move_square, new_game,
      output square_occ, square_color, turn, move_ack, move_err, game_over,
             winner_valid, winner, win_line
   );
endinterface

// File: rtl/board_ctl.sv
// board_ctl: tic-tac-toe sequencer; accepts moves, alternates turns, detects win or draw.
module board_ctl (
   input logic    pclk,
   input logic    rst,
   board_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

   localparam logic [8:0] line_mask [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                            9'h092, 9'h124, 9'h111, 9'h054};

   state_t     state, state_d;
   logic       go, ok;
   logic [8:0] sq_bits, own, occ_d, color_d;
   logic [7:0] lines, line_d;
   logic       turn_d, ack_d, err_d, over_d, wv_d, win_d;

   assign go = bus.start_en && !bus.choice_en;
   // one-hot of the requested square; squares 0 and 10..15 fall outside and give zero
   assign sq_bits = 9'((10'd1 << bus.move_square) >> 1);
   assign ok = |sq_bits && !(|(sq_bits & bus.square_occ));
   assign own = bus.square_occ & (bus.turn ? bus.square_color : ~bus.square_color);

   always_comb begin
      lines = '0;
      for (int k = 0; k < 8; k++) lines[k] = (own & line_mask[k]) == line_mask[k];
   end

   always_comb begin
      state_d = state;
      occ_d   = bus.square_occ;
      color_d = bus.square_color;
      turn_d  = bus.turn;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      over_d  = bus.game_over;
      wv_d    = bus.winner_valid;
      win_d   = bus.winner;
      line_d  = bus.win_line;
      if (bus.new_game || (state != IDLE && !go)) begin
         state_d = IDLE;
         occ_d   = '0;
         color_d = '0;
         turn_d  = 1'b0;
         over_d  = 1'b0;
         wv_d    = 1'b0;
         win_d   = 1'b0;
         line_d  = '0;
      end else begin
         case (state)
            IDLE: if (go) begin
               state_d = PLAY;
               turn_d  = bus.first_player;
            end
            PLAY: if (bus.move_valid) begin
               if (ok) begin
                  occ_d   = bus.square_occ | sq_bits;
                  color_d = bus.turn ? bus.square_color | sq_bits : bus.square_color & ~sq_bits;
                  ack_d   = 1'b1;
                  state_d = CHECK;
               end else err_d = 1'b1;
            end
            CHECK: begin
               if (|lines) begin
                  over_d  = 1'b1;
                  wv_d    = 1'b1;
                  win_d   = bus.turn;
                  line_d  = lines;
                  state_d = OVER;
               end else if (&bus.square_occ) begin
                  over_d  = 1'b1;
                  state_d = OVER;
               end else begin
                  turn_d  = ~bus.turn;
                  state_d = PLAY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_d;

   always_ff @(posedge pclk or negedge rst)
      if (!rst) begin
         bus.square_occ   <= '0;
         bus.square_color <= '0;
         bus.turn         <= 1'b0;
         bus.move_ack     <= 1'b0;
         bus.move_err     <= 1'b0;
         bus.game_over    <= 1'b0;
         bus.winner_valid <= 1'b0;
         bus.winner       <= 1'b0;
         bus.win_line     <= '0;
      end else begin
         bus.square_occ   <= occ_d;
         bus.square_color <= color_d;
         bus.turn         <= turn_d;
         bus.move_ack     <= ack_d;
         bus.move_err     <= err_d;
         bus.game_over    <= over_d;
         bus.winner_valid <= wv_d;
         bus.winner       <= win_d;
         bus.win_line     <= line_d;
      end
endmodule

// File: tb/tb_board_ctl.sv
// tb_board_ctl: directed move tables plus random games against a board-array reference model.
module tb_board_ctl;
   logic pclk, rst;
   board_if bus ();

   board_ctl dut (.pclk(pclk), .rst(rst), .bus(bus));

   initial begin
      pclk = 0;
      forever #5 pclk = ~pclk;
   end

   int n_chk = 0, n_fail = 0;
   logic       a_ack, a_err, a_turn;
   logic [8:0] a_occ, a_color;

   // reference board: -1 empty, else owner colour
   int b [9];
   int tri_sq [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   typedef struct {
      logic       fresh;
      logic       fp;
      logic [3:0] sq;
      logic       ack;
      logic       err;
      logic       turn;
      logic [8:0] occ;
      logic [8:0] color;
      logic       go2;
      logic       wv2;
      logic [7:0] wl2;
   } vec_t;

   vec_t vecs [27];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic start_game(input logic fp);
      bus.first_player = fp;
      bus.new_game = 1;
      step();
      bus.new_game = 0;
      step();
   endtask

   task automatic do_move(input logic [3:0] sq);
      bus.move_valid  = 1;
      bus.move_square = sq;
      step();
      bus.move_valid = 0;
      a_ack   = bus.move_ack;
      a_err   = bus.move_err;
      a_turn  = bus.turn;
      a_occ   = bus.square_occ;
      a_color = bus.square_color;
      step();
   endtask

   function automatic logic [7:0] wins(input int c);
      logic [7:0] w = '0;
      for (int k = 0; k < 8; k++)
         w[k] = b[tri_sq[k][0]] == c && b[tri_sq[k][1]] == c && b[tri_sq[k][2]] == c;
      return w;
   endfunction

   function automatic logic [8:0] occ_of();
      logic [8:0] o = '0;
      for (int i = 0; i < 9; i++) o[i] = b[i] >= 0;
      return o;
   endfunction

   function automatic logic [8:0] color_of();
      logic [8:0] o = '0;
      for (int i = 0; i < 9; i++) o[i] = b[i] == 1;
      return o;
   endfunction

   initial begin
      vecs = '{
         '{1,1,4'd1, 1,0,1,9'h001,9'h001,0,0,8'h00},
         '{0,1,4'd4, 1,0,0,9'h009,9'h001,0,0,8'h00},
         '{0,1,4'd2, 1,0,1,9'h00B,9'h003,0,0,8'h00},
         '{0,1,4'd5, 1,0,0,9'h01B,9'h003,0,0,8'h00},
         '{0,1,4'd3, 1,0,1,9'h01F,9'h007,1,1,8'h01},
         '{1,1,4'd5, 1,0,1,9'h010,9'h010,0,0,8'h00},
         '{0,1,4'd5, 0,1,0,9'h010,9'h010,0,0,8'h00},
         '{0,1,4'd0, 0,1,0,9'h010,9'h010,0,0,8'h00},
         '{0,1,4'd12,0,1,0,9'h010,9'h010,0,0,8'h00},
         '{1,0,4'd1, 1,0,0,9'h001,9'h000,0,0,8'h00},
         '{0,0,4'd2, 1,0,1,9'h003,9'h002,0,0,8'h00},
         '{0,0,4'd3, 1,0,0,9'h007,9'h002,0,0,8'h00},
         '{0,0,4'd5, 1,0,1,9'h017,9'h012,0,0,8'h00},
         '{0,0,4'd4, 1,0,0,9'h01F,9'h012,0,0,8'h00},
         '{0,0,4'd6, 1,0,1,9'h03F,9'h032,0,0,8'h00},
         '{0,0,4'd8, 1,0,0,9'h0BF,9'h032,0,0,8'h00},
         '{0,0,4'd7, 1,0,1,9'h0FF,9'h072,0,0,8'h00},
         '{0,0,4'd9, 1,0,0,9'h1FF,9'h072,1,0,8'h00},
         '{1,1,4'd1, 1,0,1,9'h001,9'h001,0,0,8'h00},
         '{0,1,4'd2, 1,0,0,9'h003,9'h001,0,0,8'h00},
         '{0,1,4'd3, 1,0,1,9'h007,9'h005,0,0,8'h00},
         '{0,1,4'd4, 1,0,0,9'h00F,9'h005,0,0,8'h00},
         '{0,1,4'd7, 1,0,1,9'h04F,9'h045,0,0,8'h00},
         '{0,1,4'd6, 1,0,0,9'h06F,9'h045,0,0,8'h00},
         '{0,1,4'd9, 1,0,1,9'h16F,9'h145,0,0,8'h00},
         '{0,1,4'd8, 1,0,0,9'h1EF,9'h145,0,0,8'h00},
         '{0,1,4'd5, 1,0,1,9'h1FF,9'h155,1,1,8'hC0}
      };

      rst = 0;
      bus.start_en = 1;
      bus.choice_en = 0;
      bus.first_player = 1;
      bus.move_valid = 0;
      bus.move_square = 0;
      bus.new_game = 0;
      #12;
      chk("reset_outputs", {bus.square_occ, bus.square_color, bus.turn, bus.move_ack, bus.move_err,
                            bus.game_over, bus.winner_valid, bus.winner, bus.win_line}, 0);
      @(negedge pclk);
      rst = 1;
      step();
      chk("start_turn", bus.turn, 1);

      foreach (vecs[i]) begin
         if (vecs[i].fresh) start_game(vecs[i].fp);
         do_move(vecs[i].sq);
         chk($sformatf("v%0d_ack", i), a_ack, vecs[i].ack);
         chk($sformatf("v%0d_err", i), a_err, vecs[i].err);
         chk($sformatf("v%0d_turn", i), a_turn, vecs[i].turn);
         chk($sformatf("v%0d_occ", i), a_occ, vecs[i].occ);
         chk($sformatf("v%0d_color", i), a_color, vecs[i].color);
         chk($sformatf("v%0d_over", i), bus.game_over, vecs[i].go2);
         chk($sformatf("v%0d_wv", i), bus.winner_valid, vecs[i].wv2);
         chk($sformatf("v%0d_wline", i), bus.win_line, vecs[i].wl2);
         if (vecs[i].wv2) chk($sformatf("v%0d_winner", i), bus.winner, vecs[i].turn);
      end

      // board is frozen after the double-line win
      do_move(4'd4);
      chk("frozen_ack", a_ack, 0);
      chk("frozen_err", a_err, 0);
      chk("frozen_occ", bus.square_occ, 9'h1FF);
      chk("frozen_wline", bus.win_line, 8'hC0);

      start_game(1);
      do_move(4'd1);
      do_move(4'd2);
      bus.new_game = 1;
      bus.move_valid = 1;
      bus.move_square = 5;
      step();
      chk("ng_ack", bus.move_ack, 0);
      chk("ng_clear", {bus.square_occ, bus.square_color, bus.turn, bus.game_over}, 0);
      bus.new_game = 0;
      bus.move_valid = 0;
      step();
      chk("ng_replay_turn", bus.turn, 1);

      do_move(4'd1);
      do_move(4'd2);
      bus.start_en = 0;
      step();
      chk("abort_clear", {bus.square_occ, bus.square_color, bus.turn}, 0);
      step();
      chk("abort_hold", {bus.square_occ, bus.turn}, 0);
      bus.start_en = 1;
      step();
      chk("abort_restart_turn", bus.turn, 1);

      do_move(4'd1);
      do_move(4'd2);
      @(posedge pclk);
      #3 rst = 0;
      #1 chk("async_rst", {bus.square_occ, bus.square_color, bus.turn}, 0);
      #2 rst = 1;
      step();
      chk("rst_restart_turn", bus.turn, 1);

      for (int g = 0; g < 20; g++) begin
         logic       fp, m_over, m_wv, m_win;
         logic [7:0] m_line;
         int         mt;
         fp = 1'($urandom_range(0, 1));
         start_game(fp);
         for (int i = 0; i < 9; i++) b[i] = -1;
         mt = int'(fp);
         m_over = 0;
         m_wv = 0;
         m_win = 0;
         m_line = 0;
         for (int r = 0; r < 25 && !m_over; r++) begin
            logic [3:0] sq;
            logic       acc;
            sq = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
            acc = sq >= 1 && sq <= 9 && b[sq-1] < 0;
            do_move(sq);
            chk("rnd_ack", a_ack, acc);
            chk("rnd_err", a_err, !acc);
            if (acc) begin
               b[sq-1] = mt;
               m_line = wins(mt);
               if (m_line != 0) begin
                  m_over = 1;
                  m_wv = 1;
                  m_win = mt[0];
               end else if (occ_of() == 9'h1FF) m_over = 1;
               else mt = 1 - mt;
            end
            chk("rnd_turn", bus.turn, mt[0]);
            chk("rnd_occ", bus.square_occ, occ_of());
            chk("rnd_color", bus.square_color, color_of());
            chk("rnd_over", bus.game_over, m_over);
            chk("rnd_wv", bus.winner_valid, m_wv);
            chk("rnd_wline", bus.win_line, m_line);
            if (m_wv) chk("rnd_winner", bus.winner, m_win);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/board_ctl.md
# board_ctl

Game sequencer for the tic-tac-toe board. It accepts player moves, tracks occupancy and owner of the nine squares, alternates turns and detects win or draw. It drives the `squareN` enables and `squareN_color` selects consumed by the nine per-square draw stages in the VGA pipeline. It sits between the mouse/move decoder and the drawing chain, in the `pclk` domain.

## Interface
- No parameters. Square numbering is fixed row-major: 1 = top-left, 3 = top-right, 7 = bottom-left, 9 = bottom-right.
- `pclk` in 1: pixel clock. One clock; all logic is in this domain.
- `rst` in 1: reset, asynchronous and active-low.
- `start_en` in 1: game screen active. Same signal the draw stages use.
- `choice_en` in 1: colour-choice screen active. Moves are accepted only when `start_en && !choice_en`.
- `first_player` in 1: colour of the first mover (0 = blue, 1 = yellow). Sampled on the IDLE→PLAY transition.
- `move_valid` in 1: single-cycle move request.
- `move_square` in 4: target square, 1..9. Valid when `move_valid` is high.
- `new_game` in 1: pulse that clears the board from any state.
- `square_occ` out 9: bit i-1 drives `square<i>`.
- `square_color` out 9: bit i-1 is the owner colour (0 blue, 1 yellow). The top level zero-extends it to 12 bits for `square<i>_color`.
- `turn` out 1: colour allowed to move next.
- `move_ack` out 1: one-cycle pulse, move accepted.
- `move_err` out 1: one-cycle pulse, move rejected.
- `game_over` out 1: high in OVER.
- `winner_valid` out 1: high in OVER when a line was completed.
- `winner` out 1: colour of the winner. Meaningful only when `winner_valid` is high.
- `win_line` out 8: one-hot completed line. Order: rows 1-2-3, 4-5-6, 7-8-9; columns 1-4-7, 2-5-8, 3-6-9; diagonals 1-5-9, 3-5-7 (bits 0..7).

## Operation
- States: IDLE, PLAY, CHECK, OVER. All outputs are registered.
- Reset values: state IDLE; every output 0, including `turn`.
- **IDLE**
  - Board held clear.
  - When `start_en && !choice_en`: `turn <= first_player`, go to PLAY.
- **PLAY**, on `move_valid`:
  - Accept when `move_square` is in 1..9 and that square is unoccupied. Set the occupancy bit, write the colour bit = `turn`, pulse `move_ack`, go to CHECK.
  - Reject when `move_square` is 0, 10..15, or already occupied. Pulse `move_err`; no other state change.
- **CHECK** (one cycle)
  - Evaluate all 8 lines for the mover's colour, using occupancy AND colour match.
  - Any line complete: `winner <= turn`, `winner_valid <= 1`, `win_line` <= the set of completed lines (multiple bits allowed), go to OVER.
  - Else, all 9 squares occupied: draw. `winner_valid` stays 0, go to OVER.
  - Else: toggle `turn`, return to PLAY.
- **OVER**
  - Board and result are frozen.
  - `move_valid` is ignored: no ack, no err.
- `move_valid` in IDLE or CHECK is ignored (no ack, no err). The upstream must not issue a move in the cycle after an ack.
- `new_game` in any state: clear the board and all result outputs, go to IDLE. It takes priority over a simultaneous `move_valid`.
- `start_en` low, or `choice_en` high, while in PLAY, CHECK or OVER: abort to IDLE with the board cleared.
- `rst` asserted mid-game: immediate asynchronous return to the reset values.

## Timing
- Move request sampled at edge N. At N+1: `square_occ`/`square_color` updated, `move_ack` high for exactly one cycle, state = CHECK.
- At N+2, exactly one of these holds:
  - `turn` toggled and state PLAY;
  - `game_over`, `winner_valid`, `winner` and `win_line` valid;
  - draw flagged.
- Earliest next accepted move is sampled at N+2. Peak throughput is one move per 2 cycles.
- `move_err` asserts at N+1 for one cycle and the state remains PLAY.
- `new_game` or abort sampled at N: all outputs cleared at N+1.
- IDLE→PLAY takes 1 cycle after the enable condition is seen.

## Test plan
- **Reset and start.** Release `rst`; set `first_player=1`, `start_en=1`, `choice_en=0`.
  - Expect all outputs 0 after reset.
  - Expect `turn=1` one cycle after the enable is seen.
- **Row win for the first player.** From the start above, moves 1, 4, 2, 5, 3.
  - After each move: `move_ack` pulses and `turn` alternates 1,0,1,0.
  - After move 3: `game_over=1`, `winner_valid=1`, `winner=1`, `win_line=8'h01`, `square_occ=9'h01F`, `square_color=9'h007`.
- **Rejects.** Move 5, then move 5 again, then square 0, then square 12.
  - The three bad moves each give a `move_err` pulse.
  - `square_occ` stays `9'h010`; `turn` is unchanged after the first toggle.
- **Draw.** Moves 1, 2, 3, 5, 4, 6, 8, 7, 9.
  - Expect `game_over=1`, `winner_valid=0`, `win_line=0`, `square_occ=9'h1FF`.
- **Double line and frozen board.** Fill so that the final move at square 5 completes 1-5-9 and 3-5-7 together.
  - Expect `win_line=8'hC0`.
  - A further `move_valid` produces no ack and no err.
- **Abort and async reset.** Play two moves, then:
  - pulse `new_game` together with `move_valid`: board cleared, state IDLE, no ack;
  - separately, drop `start_en` mid-game: board cleared, state IDLE;
  - separately, assert `rst` between clock edges: outputs clear before the next `pclk` edge.
